// File: rtl/dff_link_arbiter.sv
// Round-robin arbiter sharing an external DEPTH-stage single-bit DFF chain between requesters A and B.
// Optional macro DFF_LINK_ARB_DRAIN_EN adds a DRAIN state that flushes the chain with zeros between owners.
module dff_link_arbiter #(
  parameter int DEPTH = 4,
  parameter int BURST = 8,
  parameter int CNT_W = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic req_a,
  input  logic data_a,
  input  logic req_b,
  input  logic data_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic link_in,
  input  logic link_out,
  output logic out_data,
  output logic out_valid,
  output logic out_owner,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
`ifdef DFF_LINK_ARB_DRAIN_EN
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DEPTH - 1);
`endif

  state_t           state_reg, state_next;
  logic             owner_reg, owner_next;           // 0 = A, 1 = B
  logic             last_owner_reg, last_owner_next;
  logic [CNT_W-1:0] count_reg, count_next;           // beats in SERVE, flush cycles in DRAIN

  logic req_own;
  logic accept;
  logic burst_end;

  assign req_own   = owner_reg ? req_b : req_a;
  assign accept    = (state_reg == SERVE) & req_own;
  // The beat that brings the count to BURST is still accepted; a low req is not.
  assign burst_end = (state_reg == SERVE) & (~req_own | (count_reg == LAST_BEAT));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      count_reg      <= count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    count_next      = count_reg;
    case (state_reg)
      IDLE: begin
        if (req_a | req_b) begin
          state_next = SERVE;
          owner_next = (req_a & req_b) ? ~last_owner_reg : req_b;
          count_next = '0;
        end
      end
      SERVE: begin
        if (burst_end) begin
          last_owner_next = owner_reg;
          count_next      = '0;
`ifdef DFF_LINK_ARB_DRAIN_EN
          state_next      = DRAIN;
`else
          state_next      = IDLE;
`endif
        end else if (accept) begin
          count_next = count_reg + CNT_W'(1);
        end
      end
`ifdef DFF_LINK_ARB_DRAIN_EN
      DRAIN: begin
        if (count_reg == LAST_DRAIN) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    link_in = 1'b0;
    busy    = (state_reg != IDLE);
    if (state_reg == SERVE) begin
      gnt_a   = ~owner_reg;
      gnt_b   = owner_reg;
      link_in = owner_reg ? data_b : data_a;
    end
  end

  // Shadow pipeline tracks which chain stages hold accepted bits and whose they are.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_shadow
      logic valid_reg;
      logic own_reg;
      logic valid_in;
      logic own_in;
      if (gi == 0) begin : g_head
        assign valid_in = accept;
        assign own_in   = gnt_b;
      end else begin : g_tail
        assign valid_in = g_shadow[gi-1].valid_reg;
        assign own_in   = g_shadow[gi-1].own_reg;
      end
      always_ff @(posedge CLK) begin
        if (RST) begin
          valid_reg <= 1'b0;
          own_reg   <= 1'b0;
        end else begin
          valid_reg <= valid_in;
          own_reg   <= own_in;
        end
      end
    end
  endgenerate

  assign out_data  = link_out;
  assign out_valid = g_shadow[DEPTH-1].valid_reg;
  assign out_owner = g_shadow[DEPTH-1].own_reg;

endmodule

// File: tb/tb_dff_link_arbiter.sv
// Self-checking bench for dff_link_arbiter: vector table, hand sequences and a randomized run
// compared against a cycle-indexed reference model.
module tb_dff_link_arbiter;
  localparam int DEPTH = 4;
  localparam int BURST = 8;
  localparam int CNT_W = 4;
`ifdef DFF_LINK_ARB_DRAIN_EN
  localparam int GAP = DEPTH;
`else
  localparam int GAP = 0;
`endif
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst, req_a, data_a, req_b, data_b;
  logic gnt_a, gnt_b, link_in, link_out, out_data, out_valid, out_owner, busy;
  logic [DEPTH-1:0] chain = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // External DFF chain the arbiter drives.
  always @(posedge clk) chain <= {chain[DEPTH-2:0], link_in};
  assign link_out = chain[DEPTH-1];

  dff_link_arbiter #(.DEPTH(DEPTH), .BURST(BURST), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST(rst),
    .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .link_in(link_in), .link_out(link_out),
    .out_data(out_data), .out_valid(out_valid), .out_owner(out_owner), .busy(busy)
  );

  // Reference model: who holds the grant, beats taken, dead cycles left, and a
  // per-cycle history of accepted bits so outputs are looked up DEPTH cycles later.
  int m_grant = 0;   // 0 none, 1 A, 2 B
  int m_cnt = 0;
  int m_last = 1;    // 0 A, 1 B
  int m_gap = 0;
  int last_rst = 0;
  int cyc = 0;
  bit m_live = 0;
  bit h_acc [MAXC];
  bit h_dat [MAXC];
  bit h_own [MAXC];

  typedef struct {
    logic ra;
    logic da;
    logic ga;
    logic bsy;
    logic v;
    logic d;
  } vec_t;
  vec_t tbl [14];

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic rbit();
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic drive(input logic r, input logic ra, input logic da, input logic rb, input logic db);
    rst = r; req_a = ra; data_a = da; req_b = rb; data_b = db;
    @(negedge clk);
  endtask

  // Compare this cycle against the model, then advance the model across the edge.
  task automatic finish_cycle();
    logic eg_a, eg_b, elink, ev, acc, req;
    int src;
    eg_a  = (m_grant == 1);
    eg_b  = (m_grant == 2);
    elink = eg_a ? data_a : (eg_b ? data_b : 1'b0);
    if (m_live) begin
      check1("gnt_a", gnt_a, eg_a);
      check1("gnt_b", gnt_b, eg_b);
      check1("busy", busy, (m_grant != 0) || (m_gap > 0));
      check1("link_in", link_in, elink);
      src = cyc - DEPTH;
      ev = (src >= 0) && (src > last_rst) && h_acc[src];
      check1("out_valid", out_valid, ev);
      if (ev) begin
        check1("out_data", out_data, h_dat[src]);
        check1("out_owner", out_owner, h_own[src]);
      end
    end
    req = (m_grant == 1) ? req_a : req_b;
    acc = (m_grant != 0) && req;
    h_acc[cyc] = acc;
    h_dat[cyc] = elink;
    h_own[cyc] = (m_grant == 2);
    if (rst) begin
      m_grant = 0; m_cnt = 0; m_last = 1; m_gap = 0;
      last_rst = cyc; m_live = 1;
    end else if (m_grant != 0) begin
      if (acc) m_cnt++;
      if (!acc || m_cnt == BURST) begin
        m_last = m_grant - 1;
        m_grant = 0;
        m_cnt = 0;
        m_gap = GAP;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (req_a && req_b) begin
      m_grant = (m_last == 1) ? 1 : 2;
    end else if (req_a) begin
      m_grant = 1;
    end else if (req_b) begin
      m_grant = 2;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      finish_cycle();
    end
  endtask

  initial begin
    logic ra, rb, want_b, pa, pb, r;
    int gb_cnt, vb_cnt, fall_c, rise_c;
    logic [7:0] pat;

    pat = 8'b1011_0010;
    for (int i = 0; i < 14; i++) begin
      tbl[i].ra  = (i <= 8);
      tbl[i].da  = (i >= 1 && i <= 8) ? pat[8-i] : 1'b0;
      tbl[i].ga  = (i >= 1 && i <= 8);
      tbl[i].bsy = (i >= 1 && i <= 8 + GAP);
      tbl[i].v   = (i >= 5 && i <= 12);
      tbl[i].d   = (i >= 5 && i <= 12) ? pat[12-i] : 1'b0;
    end

    rst = 1'b1; req_a = 1'b0; data_a = 1'b0; req_b = 1'b0; data_b = 1'b0;
    @(posedge clk);
    #1;

    // Reset for two edges, then quiet.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); finish_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); finish_cycle();
    idle(10);

    // Single A burst from the vector table.
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, tbl[i].ra, tbl[i].da, 1'b0, 1'b0);
      check1("tbl_gnt_a", gnt_a, tbl[i].ga);
      check1("tbl_busy", busy, tbl[i].bsy);
      check1("tbl_valid", out_valid, tbl[i].v);
      if (tbl[i].v) begin
        check1("tbl_data", out_data, tbl[i].d);
        check1("tbl_owner", out_owner, 1'b0);
      end
      finish_cycle();
    end
    idle(6);

    // Contention from reset: grants alternate A, B, A, B.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); finish_cycle();
    want_b = 1'b0; pa = 1'b0; pb = 1'b0;
    for (int i = 0; i < 4 * (BURST + 1 + GAP) + 2; i++) begin
      drive(1'b0, 1'b1, rbit(), 1'b1, rbit());
      if ((gnt_a && !pa) || (gnt_b && !pb)) begin
        check1("rr_order", gnt_b, want_b);
        want_b = ~want_b;
      end
      pa = gnt_a; pb = gnt_b;
      finish_cycle();
    end
    idle(12);

    // Early release: B holds req for 4 cycles, 3 of them granted.
    gb_cnt = 0; vb_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      drive(1'b0, 1'b0, 1'b0, (k < 4), rbit());
      if (gnt_b) gb_cnt++;
      if (out_valid && out_owner) vb_cnt++;
      finish_cycle();
    end
    checkn("early_gnt_b_cycles", gb_cnt, 4);
    checkn("early_valid_b_bits", vb_cnt, 3);
    idle(12);

    // Reset at beat 5 of an A burst.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, rbit(), 1'b0, 1'b0); finish_cycle();
    end
    drive(1'b1, 1'b1, rbit(), 1'b0, 1'b0); finish_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, rbit());
    check1("rst_mid_gnt_a", gnt_a, 1'b0);
    check1("rst_mid_valid", out_valid, 1'b0);
    finish_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, rbit());
    check1("rst_mid_gnt_b", gnt_b, 1'b1);
    finish_cycle();
    idle(12);

    // Back-to-back A then B: measure the dead gap between owners.
    fall_c = -1; rise_c = -1; pa = 1'b0;
    for (int k = 0; k < 30; k++) begin
      drive(1'b0, 1'b1, rbit(), 1'b1, rbit());
      if (pa && !gnt_a && fall_c < 0) fall_c = k;
      if (gnt_b && rise_c < 0) rise_c = k;
      if (fall_c >= 0 && rise_c < 0 && k < fall_c + GAP) begin
        check1("gap_link_in", link_in, 1'b0);
        check1("gap_no_grant", gnt_a | gnt_b, 1'b0);
      end
      pa = gnt_a;
      finish_cycle();
    end
    checkn("gap_length", (fall_c >= 0 && rise_c >= 0) ? rise_c - fall_c : -1, GAP + 1);
    idle(12);

    // Randomized traffic with occasional resets.
    ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      r = ($urandom_range(0, 149) == 0);
      drive(r, ra, rbit(), rb, rbit());
      finish_cycle();
    end
    idle(DEPTH + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
